// File: rtl/hs_upload_reader.sv
// ============================================================================
// Module   : hs_upload_reader
// Purpose  : Upload (read) engine for high-score/NVRAM save. While the HPS
//            uploads on index INDEX, the game CPU is paused and each ioctl
//            read request becomes a read of game work RAM at BASE+offset.
// Options  : HS_UPLOAD_CHECKSUM_EN - offset LEN returns an 8-bit running sum
//            of every byte fetched since the upload started.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_upload_reader #(
    parameter int                ADDR_W       = 16,
    parameter logic [7:0]        INDEX        = 8'd4,
    parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(16'hC000),
    parameter int                LEN          = 256,
    parameter int                RAM_LAT      = 1,
    parameter int                PAUSE_SETTLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    input  logic [7:0]        ram_data,
    output logic              pause
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_READY  = 2'd2,
        S_FETCH  = 2'd3
    } state_t;

    localparam logic [24:0] LEN_C       = 25'(LEN);
    localparam logic [15:0] SETTLE_INIT = 16'(PAUSE_SETTLE - 1);
    // The fetch counter starts at RAM_LAT so that the capture happens in the
    // cycle where the RAM output is valid (RAM_LAT cycles after ram_read).
    localparam logic [15:0] LAT_INIT    = 16'(RAM_LAT);

    state_t            state_q;
    logic              active_q;
    logic [15:0]       cnt_q;
    logic [7:0]        ioctl_din_q;
    logic              ioctl_wait_q;
    logic [ADDR_W-1:0] ram_address_q;
    logic              ram_read_q;
    logic              pause_q;
`ifdef HS_UPLOAD_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic active;

    // Upload targets this block only when the index matches.
    assign active = ioctl_upload & (ioctl_index == INDEX);

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            active_q      <= 1'b0;
            cnt_q         <= '0;
            ioctl_din_q   <= 8'h00;
            ioctl_wait_q  <= 1'b0;
            ram_address_q <= '0;
            ram_read_q    <= 1'b0;
            pause_q       <= 1'b0;
`ifdef HS_UPLOAD_CHECKSUM_EN
            csum_q        <= 8'h00;
`endif
        end else begin
            active_q   <= active;
            ram_read_q <= 1'b0;
            if (active_q && !active) begin
                // Upload ended: release the CPU, abandon any fetch, keep din.
                state_q      <= S_IDLE;
                pause_q      <= 1'b0;
                ioctl_wait_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (active && !active_q) begin
                            state_q      <= S_SETTLE;
                            pause_q      <= 1'b1;
                            ioctl_wait_q <= 1'b1;
                            cnt_q        <= SETTLE_INIT;
`ifdef HS_UPLOAD_CHECKSUM_EN
                            csum_q       <= 8'h00;
`endif
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == 16'd0) begin
                            state_q      <= S_READY;
                            ioctl_wait_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_READY: begin
                        if (ioctl_rd) begin
                            if (ioctl_addr < LEN_C) begin
                                ram_address_q <= BASE + ADDR_W'(ioctl_addr[11:0]);
                                ram_read_q    <= 1'b1;
                                ioctl_wait_q  <= 1'b1;
                                cnt_q         <= LAT_INIT;
                                state_q       <= S_FETCH;
                            end
`ifdef HS_UPLOAD_CHECKSUM_EN
                            else if (ioctl_addr == LEN_C) begin
                                ioctl_din_q <= csum_q;
                            end
`endif
                            else begin
                                ioctl_din_q <= 8'hFF;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (cnt_q == 16'd0) begin
                            ioctl_din_q  <= ram_data;
                            ioctl_wait_q <= 1'b0;
                            state_q      <= S_READY;
`ifdef HS_UPLOAD_CHECKSUM_EN
                            csum_q       <= csum_q + ram_data;
`endif
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ioctl_din   = ioctl_din_q;
    assign ioctl_wait  = ioctl_wait_q;
    assign ram_address = ram_address_q;
    assign ram_read    = ram_read_q;
    assign pause       = pause_q;

endmodule

`default_nettype wire
